// File: rtl/tpu_pkg.sv
// Shared definitions for the accumulator and its drain-side reader.
package tpu_pkg;

  localparam int ACC_W     = 16;
  localparam int ACC_DEPTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/acc_drain.sv
// Snapshots the accumulator bank on a bank_full rise and streams it out in index order.
// Word 0 is valid the cycle after capture; words hold while out_ready is low, one word per handshake.
module acc_drain
  import tpu_pkg::*;
#(
  parameter int DATA_W = ACC_W,
  parameter int DEPTH  = ACC_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bank_full,
  input  logic [DEPTH*DATA_W-1:0] bank_data,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  drain_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              full_q;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              load;
  logic              capture;
  logic              handshake;
  logic [DATA_W-1:0] snap_q [DEPTH];

  assign capture   = bank_full & ~full_q;
  assign handshake = (state_q == SEND) & out_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake && idx_q == LAST_IDX) begin
          done_d = 1'b1;
          idx_d  = '0;
          // A rise landing on the final handshake starts the next bank seamlessly.
          if (capture) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (capture) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      full_q    <= bank_full;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      if (load) begin
        for (int k = 0; k < DEPTH; k++) begin
          snap_q[k] <= bank_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = snap_q[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_acc_drain.sv
// Randomized and directed checks of acc_drain against a queue-based stream model.
module tb_acc_drain;

  localparam int DW = 16;
  localparam int DP = 8;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             bank_full;
  logic [DP*DW-1:0] bank_data;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last, out_valid, out_ready, busy, done, overrun;

  acc_drain #(.DATA_W(DW), .DEPTH(DP), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .bank_full(bank_full), .bank_data(bank_data),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending words of the current bank, oldest first.
  typedef struct { logic [DW-1:0] d; int i; } wrd_t;
  wrd_t          exp_q[$];
  bit            full_prev  = 0;
  bit            exp_done   = 0;
  bit            exp_ovr    = 0;
  bit            started    = 0;
  logic [DW-1:0] acc_log[$];

  always @(posedge clk) begin
    bit cap, hs;
    started = 1;
    if (reset) begin
      exp_q.delete();
      full_prev = 0;
      exp_done  = 0;
      exp_ovr   = 0;
    end else begin
      cap = bank_full && !full_prev;
      hs  = (exp_q.size() > 0) && out_ready;
      exp_done = hs && (exp_q.size() == 1);
      if (hs) void'(exp_q.pop_front());
      if (cap) begin
        if (exp_q.size() == 0) begin
          for (int k = 0; k < DP; k++) exp_q.push_back('{bank_data[k*DW +: DW], k});
        end else begin
          exp_ovr = 1;
        end
      end
      full_prev = bank_full;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", out_valid, exp_q.size() > 0);
      chk("busy", busy, exp_q.size() > 0);
      chk("done", done, exp_done);
      chk("overrun", overrun, exp_ovr);
      if (exp_q.size() > 0) begin
        chk("data", out_data, exp_q[0].d);
        chk("idx", out_idx, exp_q[0].i);
        chk("last", out_last, exp_q[0].i == DP - 1);
      end else begin
        chk("last_idle", out_last, 0);
      end
      if (out_valid && out_ready) acc_log.push_back(out_data);
    end
  end

  logic [DW-1:0] cur[DP];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank();
    for (int k = 0; k < DP; k++) bank_data[k*DW +: DW] = cur[k];
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (!(out_valid && out_idx == target) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idx_timeout", n < 100, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("wait_done_timeout", n < 300, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, acc_log.size(), DP);
    for (int k = 0; k < DP && k < acc_log.size(); k++) chk(name, acc_log[k], cur[k]);
  endtask

  logic [DW-1:0] orig[DP];

  initial begin
    reset = 1'b1; bank_full = 1'b0; bank_data = '0; out_ready = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);

    // Basic stream, bank_full then held high to show no retrigger.
    for (int k = 0; k < DP; k++) cur[k] = DW'(k + 1);
    load_bank();
    out_ready = 1'b1;
    tick();
    acc_log.delete();
    bank_full = 1'b1;
    tick();
    chk("basic_first_valid", out_valid, 1);
    chk("basic_first_data", out_data, 16'h0001);
    chk("basic_first_last", out_last, 0);
    repeat (7) tick();
    chk("basic_last_data", out_data, 16'h0008);
    chk("basic_last_idx", out_idx, 7);
    chk("basic_last_flag", out_last, 1);
    tick();
    chk("basic_done", done, 1);
    chk("basic_busy_after", busy, 0);
    tick();
    chk("basic_done_pulse", done, 0);
    repeat (10) tick();
    check_log("basic_word");
    bank_full = 1'b0;
    tick();

    // Backpressure: fixed pattern then random ready.
    for (int k = 0; k < DP; k++) cur[k] = DW'($urandom);
    load_bank();
    acc_log.delete();
    bank_full = 1'b1;
    tick();
    bank_full = 1'b0;
    begin
      bit pat[6] = '{1, 0, 0, 1, 0, 1};
      for (int c = 0; c < 6; c++) begin
        out_ready = pat[c];
        tick();
      end
      for (int c = 0; c < 300 && !done; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    out_ready = 1'b1;
    tick();
    check_log("bp_word");

    // Overrun: second rise at word 3, bank_data overwritten with AAAA then FFFF.
    for (int k = 0; k < DP; k++) cur[k] = DW'($urandom);
    load_bank();
    acc_log.delete();
    bank_full = 1'b1;
    tick();
    bank_full = 1'b0;
    wait_idx(3);
    bank_data = {DP{16'hAAAA}};
    bank_full = 1'b1;
    tick();
    chk("ovr_set", overrun, 1);
    bank_data = {DP{16'hFFFF}};
    wait_done();
    tick();
    check_log("ovr_word");
    chk("ovr_sticky", overrun, 1);
    bank_full = 1'b0;
    tick();

    // Back-to-back capture on final handshake.
    do_reset();
    chk("b2b_ovr_clear", overrun, 0);
    for (int k = 0; k < DP; k++) cur[k] = DW'($urandom);
    load_bank();
    bank_full = 1'b1;
    tick();
    bank_full = 1'b0;
    wait_idx(7);
    for (int k = 0; k < DP; k++) orig[k] = DW'($urandom);
    for (int k = 0; k < DP; k++) bank_data[k*DW +: DW] = orig[k];
    bank_full = 1'b1;
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, orig[0]);
    chk("b2b_idx", out_idx, 0);
    chk("b2b_done", done, 1);
    chk("b2b_overrun", overrun, 0);
    bank_full = 1'b0;
    wait_done();
    tick();

    // Reset mid-stream, then a fresh stream from index 0.
    for (int k = 0; k < DP; k++) cur[k] = DW'($urandom);
    load_bank();
    bank_full = 1'b1;
    tick();
    bank_full = 1'b0;
    wait_idx(4);
    reset = 1'b1;
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_idx", out_idx, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_done", done, 0);
    reset = 1'b0;
    tick();
    acc_log.delete();
    bank_full = 1'b1;
    tick();
    chk("mrst_restart_idx", out_idx, 0);
    chk("mrst_restart_data", out_data, cur[0]);
    bank_full = 1'b0;
    wait_done();
    tick();
    check_log("mrst_word");

    // bank_full already high when reset releases.
    reset = 1'b1;
    bank_full = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_high_capture", out_valid, 1);
    bank_full = 1'b0;
    wait_done();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) bank_full = ~bank_full;
      if ($urandom_range(0, 3) == 0) bank_data = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 999) == 0) reset = 1'b1; else reset = 1'b0;
      tick();
    end
    reset = 1'b0;
    bank_full = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
